// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128 key schedule, one round key per handshake.
// Optional AES_KEY_EXP_REVERSE_EN: buffer all 11 keys and emit them 10 down to 0.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   // Entry a sits at bits [2047-8a -: 8]; 2047-8a == {~a, 3'b111}.
   assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_key_expand_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, EMIT, SUB, COMBINE} state_t;

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   state_t      state;
   logic [31:0] w0, w1, w2, w3, tmp;
   logic [1:0]  sub_cnt;
   logic [7:0]  rcon;
   logic [7:0]  sbox_in, sbox_out, rcon_nxt;
   logic [31:0] t, n0, n1, n2, n3;

   // RotWord feeds bytes 1,2,3,0 of w3 through the single shared S-box.
   always_comb begin
      case (sub_cnt)
         2'd0:    sbox_in = w3[23:16];
         2'd1:    sbox_in = w3[15:8];
         2'd2:    sbox_in = w3[7:0];
         default: sbox_in = w3[31:24];
      endcase
      t        = tmp ^ {rcon, 24'h0};
      n0       = w0 ^ t;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
   end

   aes_sbox u_sbox (.a(sbox_in), .y(sbox_out));

`ifdef AES_KEY_EXP_REVERSE_EN
   logic [127:0] kbuf [0:10];
   logic [3:0]   gen_idx;
   logic         gen_done;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == IDLE && start && !done)
            kbuf[0] <= key;
         else if (state == COMBINE)
            kbuf[gen_idx + 4'd1] <= {n0, n1, n2, n3};
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         w0        <= '0;
         w1        <= '0;
         w2        <= '0;
         w3        <= '0;
         tmp       <= '0;
         sub_cnt   <= '0;
         rcon      <= 8'h01;
         round_key <= '0;
         round_idx <= '0;
         rk_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef AES_KEY_EXP_REVERSE_EN
         gen_idx   <= '0;
         gen_done  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A start coinciding with the done pulse is held off one cycle.
               if (start && !done) begin
                  {w0, w1, w2, w3} <= key;
                  rcon      <= 8'h01;
                  busy      <= 1'b1;
                  round_idx <= '0;
`ifdef AES_KEY_EXP_REVERSE_EN
                  gen_idx   <= '0;
                  gen_done  <= 1'b0;
                  rk_valid  <= 1'b0;
                  sub_cnt   <= '0;
                  state     <= SUB;
`else
                  round_key <= key;
                  rk_valid  <= 1'b1;
                  state     <= EMIT;
`endif
               end
            end
            EMIT: begin
`ifdef AES_KEY_EXP_REVERSE_EN
               if (!rk_valid) begin
                  if (gen_done) begin
                     round_key <= kbuf[round_idx];
                     rk_valid  <= 1'b1;
                  end
               end else if (rk_ready) begin
                  if (round_idx == 4'd0) begin
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     round_key <= kbuf[round_idx - 4'd1];
                     round_idx <= round_idx - 4'd1;
                  end
               end
`else
               if (rk_valid && rk_ready) begin
                  rk_valid <= 1'b0;
                  if (round_idx == LAST) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     sub_cnt <= '0;
                     state   <= SUB;
                  end
               end
`endif
            end
            SUB: begin
               tmp     <= {tmp[23:0], sbox_out};
               sub_cnt <= sub_cnt + 2'd1;
               if (sub_cnt == 2'd3)
                  state <= COMBINE;
            end
            COMBINE: begin
               {w0, w1, w2, w3} <= {n0, n1, n2, n3};
               rcon <= rcon_nxt;
`ifdef AES_KEY_EXP_REVERSE_EN
               gen_idx <= gen_idx + 4'd1;
               if (gen_idx + 4'd1 == LAST) begin
                  gen_done  <= 1'b1;
                  round_idx <= LAST;
                  state     <= EMIT;
               end else begin
                  sub_cnt <= '0;
                  state   <= SUB;
               end
`else
               round_key <= {n0, n1, n2, n3};
               round_idx <= round_idx + 4'd1;
               rk_valid  <= 1'b1;
               state     <= EMIT;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed bench for aes_key_expand_seq with FIPS-197 vectors.

module tb_aes_key_expand_seq;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         rk_ready = 1'b1;
   logic [127:0] key = '0;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid, busy, done;

   localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] ONES  = {128{1'b1}};

   aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key),
      .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid),
      .rk_ready(rk_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   logic [127:0] got_key [0:10];
   int           got_cyc [0:10];
   int           done_cyc;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_sched(input logic [127:0] k);
      start = 1'b1;
      key   = k;
      tick();
      start = 1'b0;
   endtask

   // Cycle 0 is the sample right after the accepting edge.
   task automatic collect(input int stall_idx, input int stall_len, input int glitch_cyc);
      int cyc = 0;
      int stalls = 0;
      logic held = 1'b0;
      for (int i = 0; i <= 10; i++) got_cyc[i] = -1;
      done_cyc = -1;
      while (cyc < 200 && done_cyc < 0) begin
         if (done) begin
            done_cyc = cyc;
         end else begin
            if (held) begin
               check("stall_idx", 128'(round_idx), 128'(stall_idx));
               check("stall_valid", 128'(rk_valid), 128'd1);
               check("stall_key", round_key, got_key[stall_idx]);
            end
            held = 1'b0;
            rk_ready = 1'b1;
            if (rk_valid) begin
               if (got_cyc[round_idx] < 0) begin
                  got_cyc[round_idx] = cyc;
                  got_key[round_idx] = round_key;
               end
               if (int'(round_idx) == stall_idx && stalls < stall_len) begin
                  rk_ready = 1'b0;
                  held = 1'b1;
                  stalls++;
               end
            end
            start = (cyc == glitch_cyc);
            if (start) key = ONES;
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      rk_ready = 1'b1;
      if (done_cyc < 0) check("timeout", 128'd0, 128'd1);
   endtask

   initial begin
      // Reset, with a start presented while reset is asserted.
      rst_n = 1'b0;
      start = 1'b1;
      key = ONES;
      tick();
      tick();
      start = 1'b0;
      check("rst_key", round_key, 128'd0);
      check("rst_idx", 128'(round_idx), 128'd0);
      check("rst_valid", 128'(rk_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      rst_n = 1'b1;
      tick();
      check("start_in_reset_ignored", 128'(busy), 128'd0);

      // FIPS-197 key, rk_ready held high.
      start_sched(K1);
      check("s1_busy", 128'(busy), 128'd1);
      collect(-1, 0, -1);
      check("s1_k0", got_key[0], K1);
      check("s1_k0_cyc", 128'(got_cyc[0]), 128'd0);
      check("s1_k1", got_key[1], K1_1);
      check("s1_k1_cyc", 128'(got_cyc[1]), 128'd6);
      check("s1_k2", got_key[2], K1_2);
      check("s1_k10", got_key[10], K1_10);
      check("s1_k10_cyc", 128'(got_cyc[10]), 128'd60);
      check("s1_done_cyc", 128'(done_cyc), 128'd61);
      check("s1_idle_busy", 128'(busy), 128'd0);
      tick();
      check("s1_done_pulse", 128'(done), 128'd0);

      // Backpressure: idx3 held for 7 cycles.
      start_sched(K1);
      collect(3, 7, -1);
      check("s2_k3_cyc", 128'(got_cyc[3]), 128'd18);
      check("s2_k4_cyc", 128'(got_cyc[4]), 128'd31);
      check("s2_k10", got_key[10], K1_10);
      check("s2_done_cyc", 128'(done_cyc), 128'd68);
      tick();

      // Start glitch with all-ones key while busy.
      start_sched(K1);
      collect(-1, 0, 8);
      check("s5_k1", got_key[1], K1_1);
      check("s5_k2", got_key[2], K1_2);
      check("s5_k10", got_key[10], K1_10);
      check("s5_done_cyc", 128'(done_cyc), 128'd61);

      // Start alongside done is held off; the following cycle it is taken.
      start = 1'b1;
      key = '0;
      tick();
      check("start_with_done_busy", 128'(busy), 128'd0);
      tick();
      start = 1'b0;
      check("b2b_busy", 128'(busy), 128'd1);
      check("b2b_k0", round_key, 128'd0);

      // All-zero key.
      collect(-1, 0, -1);
      check("s3_k1", got_key[1], Z_1);
      check("s3_k10", got_key[10], Z_10);
      check("s3_done_cyc", 128'(done_cyc), 128'd61);
      tick();

      // Reset during SUB of round 5, then a full clean rerun.
      start_sched(K1);
      repeat (26) tick();
      check("s4_pre_idx", 128'(round_idx), 128'd4);
      check("s4_pre_busy", 128'(busy), 128'd1);
      rst_n = 1'b0;
      tick();
      check("s4_valid", 128'(rk_valid), 128'd0);
      check("s4_busy", 128'(busy), 128'd0);
      check("s4_idx", 128'(round_idx), 128'd0);
      check("s4_key", round_key, 128'd0);
      rst_n = 1'b1;
      tick();
      start_sched(K1);
      collect(-1, 0, -1);
      check("s4_k0", got_key[0], K1);
      check("s4_k1", got_key[1], K1_1);
      check("s4_k2", got_key[2], K1_2);
      check("s4_k10", got_key[10], K1_10);
      check("s4_done_cyc", 128'(done_cyc), 128'd61);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
